// File: rtl/ltc2387_adc_emulator.sv
// LTC2387 serial ADC emulator.
// Turns a cnv/clk request from the FPGA-side interface into a serial sample
// on da (and db in two-lane mode), all timed on the sys_clk_int domain.
// Optional build macro: LTC2387_EMU_TESTPAT_EN replaces sample_in with an
// internal ramp (0 after reset, +1 per accepted conversion).
module ltc2387_adc_emulator #(
  parameter int ADC_WIDTH     = 18,
  parameter int T_CONV_CYCLES = 13
) (
  input  logic                 sys_clk_int,
  input  logic                 reset_int,
  input  logic                 cnv,
  input  logic                 clk,
  input  logic                 tl,
  input  logic [ADC_WIDTH-1:0] sample_in,
  output logic                 dco,
  output logic                 da,
  output logic                 db,
  output logic                 busy
);

  localparam int CNT_W = (T_CONV_CYCLES > 1) ? $clog2(T_CONV_CYCLES) : 1;
  localparam int BIT_W = $clog2(ADC_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_READY   = 2'd2,
    S_SHIFT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 cnv_m_q, cnv_s_q, cnv_p_q;
  logic                 clk_m_q, clk_s_q, clk_p_q;
  logic                 tl_m_q, tl_s_q;
  logic                 tl_lat_q, tl_lat_d;
  logic [CNT_W-1:0]     conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADC_WIDTH-1:0] sr_q, sr_d;
  logic                 da_q, da_d;
  logic                 db_q, db_d;
  logic                 busy_q, busy_d;
  logic                 cnv_rise_s, clk_edge_s, conv_done_s, last_edge_s;
  logic [ADC_WIDTH-1:0] sr_shift_s, sample_src_s;

  // Edge detection looks only at the synchronized copies and their history.
  assign cnv_rise_s  = cnv_s_q & ~cnv_p_q;
  assign clk_edge_s  = clk_s_q ^ clk_p_q;
  assign conv_done_s = (conv_cnt_q == CNT_W'(T_CONV_CYCLES - 1));
  assign last_edge_s = tl_lat_q ? (bit_cnt_q == BIT_W'(ADC_WIDTH / 2 - 1))
                                : (bit_cnt_q == BIT_W'(ADC_WIDTH - 1));
  assign sr_shift_s  = tl_lat_q ? {sr_q[ADC_WIDTH-3:0], 2'b00}
                                : {sr_q[ADC_WIDTH-2:0], 1'b0};

  // The history stage of clk is also the dco register: same stage as da/db.
  assign dco  = clk_p_q;
  assign da   = da_q;
  assign db   = db_q;
  assign busy = busy_q;

`ifdef LTC2387_EMU_TESTPAT_EN
  logic [ADC_WIDTH-1:0] ramp_q, ramp_d;

  assign sample_src_s = ramp_q;

  // Test-pattern ramp; wraps naturally at the top of its range.
  always_ff @(posedge sys_clk_int or negedge reset_int) begin
    if (!reset_int) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  // Ramp advances once per accepted conversion.
  always_comb begin
    ramp_d = ramp_q;
    if ((state_q == S_IDLE) && cnv_rise_s) begin
      ramp_d = ramp_q + ADC_WIDTH'(1);
    end else begin
      ramp_d = ramp_q;
    end
  end
`else
  assign sample_src_s = sample_in;
`endif

  // Two-flop synchronizers for the asynchronous pins plus edge history.
  always_ff @(posedge sys_clk_int or negedge reset_int) begin
    if (!reset_int) begin
      cnv_m_q <= 1'b0; cnv_s_q <= 1'b0; cnv_p_q <= 1'b0;
      clk_m_q <= 1'b0; clk_s_q <= 1'b0; clk_p_q <= 1'b0;
      tl_m_q  <= 1'b0; tl_s_q  <= 1'b0;
    end else begin
      cnv_m_q <= cnv; cnv_s_q <= cnv_m_q; cnv_p_q <= cnv_s_q;
      clk_m_q <= clk; clk_s_q <= clk_m_q; clk_p_q <= clk_s_q;
      tl_m_q  <= tl;  tl_s_q  <= tl_m_q;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk_int or negedge reset_int) begin
    if (!reset_int) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; cnv outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = cnv_rise_s  ? S_CONVERT : S_IDLE;
      S_CONVERT: state_d = conv_done_s ? S_READY   : S_CONVERT;
      S_READY, S_SHIFT: begin
        if (clk_edge_s) begin
          state_d = last_edge_s ? S_IDLE : S_SHIFT;
        end else begin
          state_d = state_q;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM output/datapath next values: latch, count, present and shift bits.
  always_comb begin
    tl_lat_d   = tl_lat_q;
    conv_cnt_d = conv_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    da_d       = da_q;
    db_d       = db_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (cnv_rise_s) begin
          sr_d       = sample_src_s;
          tl_lat_d   = tl_s_q;
          conv_cnt_d = '0;
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
          da_d   = 1'b0;
          db_d   = 1'b0;
        end
      end
      S_CONVERT: begin
        if (conv_done_s) begin
          da_d      = sr_q[ADC_WIDTH-1];
          db_d      = tl_lat_q ? sr_q[ADC_WIDTH-2] : 1'b0;
          bit_cnt_d = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + CNT_W'(1);
        end
      end
      S_READY, S_SHIFT: begin
        if (clk_edge_s && last_edge_s) begin
          sr_d      = '0;
          bit_cnt_d = '0;
          da_d      = 1'b0;
          db_d      = 1'b0;
          busy_d    = 1'b0;
        end else if (clk_edge_s) begin
          sr_d      = sr_shift_s;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          da_d      = sr_shift_s[ADC_WIDTH-1];
          db_d      = tl_lat_q ? sr_shift_s[ADC_WIDTH-2] : 1'b0;
        end else begin
          sr_d = sr_q;
        end
      end
      default: begin
        sr_d   = '0;
        da_d   = 1'b0;
        db_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk_int or negedge reset_int) begin
    if (!reset_int) begin
      tl_lat_q   <= 1'b0;
      conv_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      da_q       <= 1'b0;
      db_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tl_lat_q   <= tl_lat_d;
      conv_cnt_q <= conv_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      da_q       <= da_d;
      db_q       <= db_d;
      busy_q     <= busy_d;
    end
  end

endmodule
